alu_seq: RTL

- Parametrised, registered successor to the datapath ALU.
- Adds a start/busy/done handshake, a WIDTH-generic datapath, a true multi-cycle restoring divider (unsigned quotient and remainder), unsigned compare, and signed-overflow/zero flags.
- Sits in the execute stage; the control FSM issues one operation at a time and waits for done.

---
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle between the execute-stage control FSM and alu_seq.
interface alu_seq_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [3:0]       alu_ctr;
   logic [WIDTH-1:0] alu_src1;
   logic [WIDTH-1:0] alu_src2;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] alu_result;
   logic             zero_bit;
   logic             ovf;

   // Control FSM side: issues operations and waits for done.
   modport master (
      output start, alu_ctr, alu_src1, alu_src2,
      input  busy, done, alu_result, zero_bit, ovf
   );

   // ALU side.
   modport slave (
      input  start, alu_ctr, alu_src1, alu_src2,
      output busy, done, alu_result, zero_bit, ovf
   );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake. Logic, add/sub, signed and
// unsigned compare complete in one cycle; divu/mod use a WIDTH-step restoring
// divider. Division by zero takes a one-cycle fast path.
module alu_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input logic      clk,
   input logic      rst,
   alu_seq_if.slave bus
);

   localparam logic [3:0] OpAnd  = 4'b0000;
   localparam logic [3:0] OpOr   = 4'b0001;
   localparam logic [3:0] OpXor  = 4'b0010;
   localparam logic [3:0] OpNor  = 4'b0011;
   localparam logic [3:0] OpSlt  = 4'b0100;
   localparam logic [3:0] OpAdd  = 4'b0101;
   localparam logic [3:0] OpSub  = 4'b0110;
   localparam logic [3:0] OpMod  = 4'b0111;
   localparam logic [3:0] OpDivu = 4'b1000;
   localparam logic [3:0] OpSltu = 4'b1001;

   localparam int unsigned Msb = WIDTH - 1;

   typedef enum logic [0:0] {StIdle, StDiv} state_e;

   state_e           r_state, w_state_d;
   logic [3:0]       r_op, w_op_d;
   logic [WIDTH-1:0] r_b, w_b_d;
   logic [WIDTH-1:0] r_rem, w_rem_d;
   logic [WIDTH-1:0] r_quo, w_quo_d;
   logic [CNT_W-1:0] r_cnt, w_cnt_d;
   logic             r_done, w_done_d;
   logic [WIDTH-1:0] r_result, w_result_d;
   logic             r_zero, w_zero_d;
   logic             r_ovf, w_ovf_d;

   // Single-cycle datapath, fed straight from the bus so the result lands at accept.
   logic [WIDTH-1:0] w_a, w_bin, w_sum, w_diff, w_single;
   logic             w_slt, w_sltu, w_ovf_add, w_ovf_sub, w_single_ovf;

   // Restoring divide step. The shifted remainder needs one extra bit since it
   // may reach 2*B-1 before the subtract.
   logic [WIDTH:0]   w_rem_sh, w_rem_sub;
   logic             w_rem_ge;
   logic [WIDTH-1:0] w_rem_step, w_quo_step;

   assign w_a    = bus.alu_src1;
   assign w_bin  = bus.alu_src2;
   assign w_sum  = w_a + w_bin;
   assign w_diff = w_a - w_bin;
   assign w_slt  = $signed(w_a) < $signed(w_bin);
   assign w_sltu = w_a < w_bin;

   assign w_ovf_add = (w_a[Msb] == w_bin[Msb]) && (w_sum[Msb] != w_a[Msb]);
   assign w_ovf_sub = (w_a[Msb] != w_bin[Msb]) && (w_diff[Msb] != w_a[Msb]);

   assign w_rem_sh   = {r_rem, r_quo[Msb]};
   assign w_rem_sub  = w_rem_sh - {1'b0, r_b};
   assign w_rem_ge   = w_rem_sh >= {1'b0, r_b};
   assign w_rem_step = w_rem_ge ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
   assign w_quo_step = {r_quo[WIDTH-2:0], w_rem_ge};

   // Select the single-cycle result; reserved opcodes yield zero.
   always_comb begin
      w_single     = '0;
      w_single_ovf = 1'b0;
      case (bus.alu_ctr)
         OpAnd:   w_single = w_a & w_bin;
         OpOr:    w_single = w_a | w_bin;
         OpXor:   w_single = w_a ^ w_bin;
         OpNor:   w_single = ~(w_a | w_bin);
         OpSlt:   w_single = {{(WIDTH-1){1'b0}}, w_slt};
         OpSltu:  w_single = {{(WIDTH-1){1'b0}}, w_sltu};
         OpAdd: begin
            w_single     = w_sum;
            w_single_ovf = w_ovf_add;
         end
         OpSub: begin
            w_single     = w_diff;
            w_single_ovf = w_ovf_sub;
         end
         default: w_single = '0;
      endcase
   end

   // Next-state, divider and result-register update.
   always_comb begin
      w_state_d  = r_state;
      w_op_d     = r_op;
      w_b_d      = r_b;
      w_rem_d    = r_rem;
      w_quo_d    = r_quo;
      w_cnt_d    = r_cnt;
      w_done_d   = 1'b0;
      w_result_d = r_result;
      w_zero_d   = r_zero;
      w_ovf_d    = r_ovf;

      unique case (r_state)
         StIdle: begin
            if (bus.start) begin
               w_op_d = bus.alu_ctr;
               w_b_d  = w_bin;
               if ((bus.alu_ctr == OpDivu || bus.alu_ctr == OpMod) && w_bin != '0) begin
                  w_rem_d   = '0;
                  w_quo_d   = w_a;
                  w_cnt_d   = '0;
                  w_state_d = StDiv;
               end else begin
                  w_done_d = 1'b1;
                  if (bus.alu_ctr == OpDivu) begin
                     w_result_d = '1;
                     w_ovf_d    = 1'b0;
                  end else if (bus.alu_ctr == OpMod) begin
                     w_result_d = w_a;
                     w_ovf_d    = 1'b0;
                  end else begin
                     w_result_d = w_single;
                     w_ovf_d    = w_single_ovf;
                  end
                  w_zero_d = ~|w_result_d;
               end
            end
         end
         StDiv: begin
            w_rem_d = w_rem_step;
            w_quo_d = w_quo_step;
            w_cnt_d = r_cnt + 1'b1;
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
               w_done_d   = 1'b1;
               w_result_d = (r_op == OpMod) ? w_rem_step : w_quo_step;
               w_zero_d   = ~|w_result_d;
               w_ovf_d    = 1'b0;
               w_state_d  = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   // State and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= StIdle;
         r_op     <= '0;
         r_b      <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_cnt    <= '0;
         r_done   <= 1'b0;
         r_result <= '0;
         r_zero   <= 1'b1;
         r_ovf    <= 1'b0;
      end else begin
         r_state  <= w_state_d;
         r_op     <= w_op_d;
         r_b      <= w_b_d;
         r_rem    <= w_rem_d;
         r_quo    <= w_quo_d;
         r_cnt    <= w_cnt_d;
         r_done   <= w_done_d;
         r_result <= w_result_d;
         r_zero   <= w_zero_d;
         r_ovf    <= w_ovf_d;
      end
   end

   assign bus.busy       = (r_state == StDiv);
   assign bus.done       = r_done;
   assign bus.alu_result = r_result;
   assign bus.zero_bit   = r_zero;
   assign bus.ovf        = r_ovf;

endmodule
